dilithium_verify_ingress: RTL and testbench

- Receiver end of the verify-mode load/unload word stream.
- Accepts the host's valid/ready word stream: rho, c, z, t1, message length, message, h.
- Tags every word with field ID and word index, and forwards it through a one-entry registered slice to the core's buffers.
- Returns the single verify-result word to the host on the output handshake.

---
 rtl/dilithium_pkg.sv | 52 +++++
 rtl/stream_reg_slice.sv | 43 ++++
 rtl/dilithium_verify_ingress.sv | 203 ++++++++++++++++++++
 tb/tb_dilithium_verify_ingress.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared definitions for the Dilithium verify stream: field tags, mode encodings
// and per-security-level word counts for a given stream word width.
package dilithium_pkg;

  typedef enum logic [2:0] {
    F_RHO  = 3'd0,
    F_C    = 3'd1,
    F_Z    = 3'd2,
    F_T1   = 3'd3,
    F_MLEN = 3'd4,
    F_MSG  = 3'd5,
    F_H    = 3'd6
  } field_t;

  localparam logic MODE_LOW_RES   = 1'b0;
  localparam logic MODE_HIGH_PERF = 1'b1;

  function automatic int unsigned ceil_words(input int unsigned bits, input int unsigned w);
    return (bits + w - 1) / w;
  endfunction

  function automatic int unsigned seed_words_num(input int unsigned w);
    return ceil_words(256, w);
  endfunction

  // z: l polynomials of 256 coeffs packed at 18 (level 2) or 20 bits
  function automatic int unsigned z_words_num(input int unsigned sec, input int unsigned w);
    case (sec)
      3:       return ceil_words(5 * 256 * 20, w);
      5:       return ceil_words(7 * 256 * 20, w);
      default: return ceil_words(4 * 256 * 18, w);
    endcase
  endfunction

  function automatic int unsigned t1_words_num(input int unsigned sec, input int unsigned w);
    case (sec)
      3:       return ceil_words(6 * 256 * 10, w);
      5:       return ceil_words(8 * 256 * 10, w);
      default: return ceil_words(4 * 256 * 10, w);
    endcase
  endfunction

  // h: omega + k bytes
  function automatic int unsigned h_words_num(input int unsigned sec, input int unsigned w);
    case (sec)
      3:       return ceil_words((55 + 6) * 8, w);
      5:       return ceil_words((75 + 8) * 8, w);
      default: return ceil_words((80 + 4) * 8, w);
    endcase
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry registered valid/ready slice; accepts a new word while draining.
module stream_reg_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dilithium_verify_ingress.sv
// Verify-mode ingress: tags host words with field/index, forwards them through a
// register slice to the core, and returns the single verify-result word.
module dilithium_verify_ingress
  import dilithium_pkg::*;
#(
  parameter int unsigned HIGH_PERF = 1,
  parameter int unsigned SEC_LEVEL = 2,
  parameter int unsigned W         = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          valid_i,
  output logic          ready_i,
  input  logic [W-1:0]  data_i,
  output logic          fld_valid,
  input  logic          fld_ready,
  output logic [W-1:0]  fld_data,
  output logic [2:0]    fld_id,
  output logic [15:0]   fld_idx,
  output logic          fld_last,
  output logic [W-1:0]  msg_len_o,
  input  logic          res_valid,
  input  logic          res_accept,
  output logic          valid_o,
  input  logic          ready_o,
  output logic [W-1:0]  data_o,
  output logic          done
);

  localparam int unsigned SEED_WORDS = seed_words_num(W);
  localparam int unsigned Z_WORDS    = z_words_num(SEC_LEVEL, W);
  localparam int unsigned T1_WORDS   = t1_words_num(SEC_LEVEL, W);
  localparam int unsigned H_WORDS    = h_words_num(SEC_LEVEL, W);
  localparam int unsigned BPW        = W / 8;
  localparam int unsigned BPW_SH     = $clog2(BPW);
  localparam logic        MODE       = (HIGH_PERF != 0) ? MODE_HIGH_PERF : MODE_LOW_RES;
  localparam int unsigned PW         = W + 3 + 16 + 1;

  typedef enum logic [3:0] {
    S_IDLE, LD_RHO, LD_C, LD_Z, LD_T1, LD_MLEN, LD_MSG, LD_H, S_WAIT_RES, S_RESULT
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   msg_len_q, msg_len_d;
  logic           pend_q, pend_d;
  logic           pend_acc_q, pend_acc_d;
  logic           res_q, res_d;
  logic           vo_q, vo_d;
  logic           done_q, done_d;

  logic           is_load, slice_rdy, in_xfer, field_last;
  logic [W-1:0]   cur_words, msg_words;
  logic [W:0]     msg_sum;
  field_t         cur_id;
  logic [PW-1:0]  slice_out;

  function automatic state_t next_load(input state_t s);
    if (MODE == MODE_HIGH_PERF) begin
      case (s)
        LD_RHO:  return LD_C;
        LD_C:    return LD_Z;
        LD_Z:    return LD_T1;
        LD_T1:   return LD_MLEN;
        LD_MLEN: return LD_MSG;
        LD_MSG:  return LD_H;
        default: return S_WAIT_RES;
      endcase
    end else begin
      case (s)
        LD_RHO:  return LD_T1;
        LD_T1:   return LD_C;
        LD_C:    return LD_Z;
        LD_Z:    return LD_H;
        LD_H:    return LD_MLEN;
        LD_MLEN: return LD_MSG;
        default: return S_WAIT_RES;
      endcase
    end
  endfunction

  // msg_len_q is valid from the cycle after the MLEN word, which is the earliest MSG transfer
  always_comb begin
    msg_sum   = {1'b0, msg_len_q} + (W+1)'(BPW - 1);
    msg_words = W'(msg_sum >> BPW_SH);
    if (msg_words == '0) msg_words = W'(1);
  end

  always_comb begin
    cur_id    = F_RHO;
    cur_words = W'(SEED_WORDS);
    case (state_q)
      LD_C:    begin cur_id = F_C;    cur_words = W'(SEED_WORDS); end
      LD_Z:    begin cur_id = F_Z;    cur_words = W'(Z_WORDS);    end
      LD_T1:   begin cur_id = F_T1;   cur_words = W'(T1_WORDS);   end
      LD_MLEN: begin cur_id = F_MLEN; cur_words = W'(1);          end
      LD_MSG:  begin cur_id = F_MSG;  cur_words = msg_words;      end
      LD_H:    begin cur_id = F_H;    cur_words = W'(H_WORDS);    end
      default: ;
    endcase
  end

  assign is_load    = state_q inside {LD_RHO, LD_C, LD_Z, LD_T1, LD_MLEN, LD_MSG, LD_H};
  assign ready_i    = is_load && slice_rdy;
  assign in_xfer    = valid_i && ready_i;
  assign field_last = (cnt_q == cur_words - W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    msg_len_d  = msg_len_q;
    pend_d     = pend_q;
    pend_acc_d = pend_acc_q;
    res_d      = res_q;
    vo_d       = vo_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = LD_RHO;
          cnt_d     = '0;
          msg_len_d = '0;
          pend_d    = 1'b0;
        end
      end
      S_WAIT_RES: begin
        if (res_valid || pend_q) begin
          res_d   = (res_valid ? res_accept : pend_acc_q) ^ MODE;
          vo_d    = 1'b1;
          pend_d  = 1'b0;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (ready_o) begin
          vo_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        // a verdict arriving while words are still loading is kept for S_WAIT_RES
        if (res_valid) begin
          pend_d     = 1'b1;
          pend_acc_d = res_accept;
        end
        if (in_xfer) begin
          if (state_q == LD_MLEN) msg_len_d = data_i;
          if (field_last) begin
            cnt_d   = '0;
            state_d = next_load(state_q);
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      msg_len_q  <= '0;
      pend_q     <= 1'b0;
      pend_acc_q <= 1'b0;
      res_q      <= 1'b0;
      vo_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      msg_len_q  <= msg_len_d;
      pend_q     <= pend_d;
      pend_acc_q <= pend_acc_d;
      res_q      <= res_d;
      vo_q       <= vo_d;
      done_q     <= done_d;
    end
  end

  stream_reg_slice #(.WIDTH(PW)) u_slice (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_xfer),
    .in_ready_o  (slice_rdy),
    .in_data_i   ({data_i, cur_id, cnt_q[15:0], field_last}),
    .out_valid_o (fld_valid),
    .out_ready_i (fld_ready),
    .out_data_o  (slice_out)
  );

  assign fld_data  = slice_out[PW-1 -: W];
  assign fld_id    = slice_out[19:17];
  assign fld_idx   = slice_out[16:1];
  assign fld_last  = slice_out[0];
  assign msg_len_o = msg_len_q;
  assign valid_o   = vo_q;
  assign data_o    = {{(W-1){1'b0}}, res_q};
  assign done      = done_q;

endmodule

// File: tb/tb_dilithium_verify_ingress.sv
// Randomized bench: instance 0 is high-perf, instance 1 low-res; both level 2, W=64.
module tb_dilithium_verify_ingress;
  import dilithium_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  id;
    logic [15:0] idx;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst[2], start[2], valid_i[2], ready_i[2];
  logic        fld_valid[2], fld_ready[2], fld_last[2];
  logic        res_valid[2], res_accept[2], valid_o[2], ready_o[2], done[2];
  logic [63:0] data_i[2], fld_data[2], msg_len_o[2], data_o[2];
  logic [2:0]  fld_id[2];
  logic [15:0] fld_idx[2];

  word_t exp_q[2][$];
  bit    active[2];
  int    bp_hold[2];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  dilithium_verify_ingress #(.HIGH_PERF(1), .SEC_LEVEL(2), .W(64)) u_hp (
    .clk(clk), .rst(rst[0]), .start(start[0]), .valid_i(valid_i[0]), .ready_i(ready_i[0]),
    .data_i(data_i[0]), .fld_valid(fld_valid[0]), .fld_ready(fld_ready[0]),
    .fld_data(fld_data[0]), .fld_id(fld_id[0]), .fld_idx(fld_idx[0]), .fld_last(fld_last[0]),
    .msg_len_o(msg_len_o[0]), .res_valid(res_valid[0]), .res_accept(res_accept[0]),
    .valid_o(valid_o[0]), .ready_o(ready_o[0]), .data_o(data_o[0]), .done(done[0])
  );

  dilithium_verify_ingress #(.HIGH_PERF(0), .SEC_LEVEL(2), .W(64)) u_lr (
    .clk(clk), .rst(rst[1]), .start(start[1]), .valid_i(valid_i[1]), .ready_i(ready_i[1]),
    .data_i(data_i[1]), .fld_valid(fld_valid[1]), .fld_ready(fld_ready[1]),
    .fld_data(fld_data[1]), .fld_id(fld_id[1]), .fld_idx(fld_idx[1]), .fld_last(fld_last[1]),
    .msg_len_o(msg_len_o[1]), .res_valid(res_valid[1]), .res_accept(res_accept[1]),
    .valid_o(valid_o[1]), .ready_o(ready_o[1]), .data_o(data_o[1]), .done(done[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic int words_of(input field_t f, input logic [63:0] mlen);
    case (f)
      F_RHO, F_C: return 4;
      F_Z:        return 288;
      F_T1:       return 160;
      F_MLEN:     return 1;
      F_H:        return 11;
      default:    return (mlen == 0) ? 1 : int'((mlen + 7) / 8);
    endcase
  endfunction

  task automatic check_idle(input int m);
    check("rst_ready_i",   ready_i[m],   0);
    check("rst_fld_valid", fld_valid[m], 0);
    check("rst_fld_data",  fld_data[m],  0);
    check("rst_fld_id",    fld_id[m],    0);
    check("rst_fld_idx",   fld_idx[m],   0);
    check("rst_fld_last",  fld_last[m],  0);
    check("rst_msg_len_o", msg_len_o[m], 0);
    check("rst_valid_o",   valid_o[m],   0);
    check("rst_data_o",    data_o[m],    0);
    check("rst_done",      done[m],      0);
  endtask

  // Core-side sink: random backpressure, with forced stall windows
  always begin
    @(posedge clk);
    #2;
    for (int m = 0; m < 2; m++) begin
      if (bp_hold[m] > 0) begin
        fld_ready[m] = 1'b0;
        bp_hold[m]--;
      end else begin
        fld_ready[m] = ($urandom_range(0, 7) != 0);
      end
    end
  end

  always @(negedge clk) begin : mon
    word_t w;
    for (int m = 0; m < 2; m++) begin
      if (!rst[m]) begin
        check($sformatf("ready_i%0d", m), ready_i[m], active[m] && (!fld_valid[m] || fld_ready[m]));
        if (fld_valid[m] && fld_ready[m]) begin
          if (exp_q[m].size() == 0) begin
            check($sformatf("fld_extra%0d", m), {fld_data[m], fld_id[m], fld_idx[m], fld_last[m]}, 0);
          end else begin
            w = exp_q[m].pop_front();
            check($sformatf("fld%0d", m), {fld_data[m], fld_id[m], fld_idx[m], fld_last[m]}, w);
          end
        end
      end
    end
  end

  task automatic run_txn(input int m, input logic [63:0] mlen, input bit acc, input bit early,
                         input bit gap_msg, input bit bp_z, input bit abort_z, input int ro_delay);
    word_t  sched[$];
    word_t  w;
    field_t ord[7];
    int     n, budget;
    logic   exp_res;
    bit     gap_done = 0;

    if (m == 0) ord = '{F_RHO, F_C, F_Z, F_T1, F_MLEN, F_MSG, F_H};
    else        ord = '{F_RHO, F_T1, F_C, F_Z, F_H, F_MLEN, F_MSG};
    for (int f = 0; f < 7; f++) begin
      n = words_of(ord[f], mlen);
      for (int i = 0; i < n; i++) begin
        w.data = (ord[f] == F_MLEN) ? mlen : {$urandom, $urandom};
        w.id   = ord[f];
        w.idx  = 16'(i);
        w.last = (i == n - 1);
        sched.push_back(w);
      end
    end

    @(posedge clk) #1 start[m] = 1'b1;
    @(posedge clk) #1 start[m] = 1'b0;
    active[m] = 1'b1;

    for (int k = 0; k < sched.size(); k++) begin
      if (abort_z && sched[k].id == F_Z && sched[k].idx == 100) begin
        valid_i[m] = 1'b0;
        rst[m]     = 1'b1;
        active[m]  = 1'b0;
        @(posedge clk) #1 rst[m] = 1'b0;
        @(negedge clk);
        check_idle(m);
        exp_q[m].delete();
        return;
      end
      if (gap_msg && !gap_done && sched[k].id == F_MSG) begin
        gap_done = 1;
        repeat (10000) @(posedge clk);
        #1;
      end
      if (early && k == sched.size() - 3) begin
        res_valid[m]  = 1'b1;
        res_accept[m] = acc;
        @(posedge clk) #1 res_valid[m] = 1'b0;
      end
      if (bp_z && sched[k].id == F_Z && sched[k].idx == 50) begin
        bp_hold[m] = 7;
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      valid_i[m] = 1'b1;
      data_i[m]  = sched[k].data;
      budget = 0;
      @(negedge clk);
      while (!ready_i[m]) begin
        budget++;
        if (budget > 500) begin
          check("ready_i_timeout", 0, 1);
          finish_test();
        end
        @(negedge clk);
      end
      exp_q[m].push_back(sched[k]);
      @(posedge clk) #1;
      valid_i[m] = 1'b0;
    end
    active[m] = 1'b0;
    check("msg_len_o", msg_len_o[m], mlen);

    if (!early) begin
      repeat (3) @(posedge clk);
      #1;
      res_valid[m]  = 1'b1;
      res_accept[m] = acc;
      @(posedge clk) #1 res_valid[m] = 1'b0;
    end

    exp_res = (m == 0) ? !acc : acc;
    budget = 0;
    @(negedge clk);
    while (!valid_o[m]) begin
      budget++;
      if (budget > 50) begin
        check("valid_o_timeout", 0, 1);
        finish_test();
      end
      @(negedge clk);
    end
    check("valid_o", valid_o[m], 1);
    check("data_o", data_o[m], {63'b0, exp_res});
    for (int c = 1; c <= ro_delay; c++) begin
      @(posedge clk) #1;
      if (c == ro_delay) ready_o[m] = 1'b1;
      @(negedge clk);
      check("valid_o_hold", valid_o[m], 1);
      check("data_o_hold", data_o[m], {63'b0, exp_res});
      check("done_early", done[m], 0);
    end
    @(posedge clk) #1 ready_o[m] = 1'b0;
    @(negedge clk);
    check("done_pulse", done[m], 1);
    check("valid_o_clear", valid_o[m], 0);
    @(negedge clk);
    check("done_single", done[m], 0);

    budget = 0;
    while (exp_q[m].size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("words_drained", exp_q[m].size(), 0);
  endtask

  initial begin
    #5_000_000;
    check("watchdog", 0, 1);
    finish_test();
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      rst[m] = 1'b1; start[m] = 1'b0; valid_i[m] = 1'b0; data_i[m] = '0;
      res_valid[m] = 1'b0; res_accept[m] = 1'b0; ready_o[m] = 1'b0;
      fld_ready[m] = 1'b0; active[m] = 1'b0; bp_hold[m] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check_idle(0);
    check_idle(1);

    run_txn(0, 64'd33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    run_txn(1, 64'd33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_txn(0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    run_txn(1, 64'($urandom_range(1, 100)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    run_txn(0, 64'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run_txn(0, 64'($urandom_range(1, 100)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 2);

    finish_test();
  end

endmodule
